// File: rtl/debounce_channel.sv
// One debounced input: a reset-cleared synchronizer chain, a stability counter,
// and the registered clean level with single-cycle rise/fall pulses.
module debounce_channel #(
  parameter int STABLE_CYCLES = 100000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: every flop, the synchronizer included, clears on reset so no stale
    // pre-reset sample can start a count after release.
    if (!reset_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the chain shift and the counter read
      // the previous-cycle values regardless of statement order.
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == TERM) begin
        // Change has persisted long enough: commit it and pulse once.
        r_level <= w_s;
        r_cnt   <= '0;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/input_debouncer.sv
// N independent debounce channels for raw board inputs; wiring only.
module input_debouncer #(
  parameter int N             = 6,
  parameter int STABLE_CYCLES = 100000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (raw[g]),
      .level  (level[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

endmodule
